// File: rtl/secuenciador_corrimiento.sv
// -----------------------------------------------------------------------------
// secuenciador_corrimiento
//
// Sequences a multi-step shift or rotate of a 4-bit operand through an external
// combinational 4-bit shift unit. On an accepted start, the block captures the
// operand, the operation and the step count. It then feeds the register back
// through the shift unit once per cycle until every step is done. Last, it
// pulses done for one cycle.
//
// Optional feature (macro ARITH_SHIFT_EN):
//   When defined, op=01 with arith=1 performs a sign-preserving right shift
//   (ir = r[3]). When undefined, the arith port is ignored.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   start request, honoured only in idle
//   dato   in   [3:0] initial operand
//   op     in   [1:0] 00 lsl, 01 lsr, 10 rol, 11 ror
//   cant   in   [2:0] number of single-bit steps (0..7)
//   arith  in   arithmetic right shift select (ARITH_SHIFT_EN only)
//   clr    in   synchronous clear / abort
//   s_i    in   [3:0] result from the shift unit
//   h      out  [1:0] shift-unit select: 00 pass, 01 left, 10 right, 11 zero
//   f      out  [3:0] operand to the shift unit (the internal register)
//   il     out  serial fill bit for left shifts
//   ir     out  serial fill bit for right shifts
//   q      out  [3:0] current register value
//   ready  out  high while idle
//   done   out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module secuenciador_corrimiento (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dato,
  input  logic [1:0] op,
  input  logic [2:0] cant,
  input  logic       arith,
  input  logic       clr,
  input  logic [3:0] s_i,
  output logic [1:0] h,
  output logic [3:0] f,
  output logic       il,
  output logic       ir,
  output logic [3:0] q,
  output logic       ready,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e     state_q;
  logic [3:0] r_q;
  logic [2:0] cnt_q;
  logic [1:0] op_q;
  logic       ready_q;
  logic       done_q;

`ifdef ARITH_SHIFT_EN
  logic       arith_q;
`else
  // arith has no effect in this build.
  logic       unused_arith;
  assign unused_arith = arith;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= 4'b0000;
      cnt_q   <= 3'd0;
      op_q    <= 2'b00;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef ARITH_SHIFT_EN
      arith_q <= 1'b0;
`endif
    end else if (clr) begin
      // The shift unit is forced to zero (h=11), so this clears r.
      state_q <= StIdle;
      r_q     <= s_i;
      cnt_q   <= 3'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            r_q     <= dato;
            op_q    <= op;
            cnt_q   <= cant;
`ifdef ARITH_SHIFT_EN
            arith_q <= arith;
`endif
            ready_q <= 1'b0;
            if (cant != 3'd0) begin
              state_q <= StShift;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StShift: begin
          r_q   <= s_i;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Shift-unit control decoded from the current state and the latched op.
  always_comb begin
    h  = 2'b00;
    il = 1'b0;
    ir = 1'b0;
    if (clr) begin
      h = 2'b11;
    end else if (state_q == StShift) begin
      h = op_q[0] ? 2'b10 : 2'b01;
    end
    unique case (op_q)
      2'b10:   il = r_q[3];
      2'b11:   ir = r_q[0];
`ifdef ARITH_SHIFT_EN
      2'b01:   ir = arith_q ? r_q[3] : 1'b0;
`endif
      default: begin
        il = 1'b0;
        ir = 1'b0;
      end
    endcase
  end

  assign f     = r_q;
  assign q     = r_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_secuenciador_corrimiento.sv
module tb_secuenciador_corrimiento;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dato;
  logic [1:0] op;
  logic [2:0] cant;
  logic       arith;
  logic       clr;
  logic [3:0] s_i;
  logic [1:0] h;
  logic [3:0] f;
  logic       il;
  logic       ir;
  logic [3:0] q;
  logic       ready;
  logic       done;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] q;
    int         lat;
  } exp_t;

  exp_t sb[$];

`ifdef ARITH_SHIFT_EN
  localparam bit ArithEn = 1'b1;
`else
  localparam bit ArithEn = 1'b0;
`endif

  secuenciador_corrimiento dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dato  (dato),
    .op    (op),
    .cant  (cant),
    .arith (arith),
    .clr   (clr),
    .s_i   (s_i),
    .h     (h),
    .f     (f),
    .il    (il),
    .ir    (ir),
    .q     (q),
    .ready (ready),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream combinational 4-bit shift unit.
  always_comb begin
    case (h)
      2'b00:   s_i = f;
      2'b01:   s_i = {f[2:0], il};
      2'b10:   s_i = {ir, f[3:1]};
      default: s_i = 4'b0000;
    endcase
  end

  function automatic logic [3:0] ref_shift(input logic [3:0] d, input logic [1:0] o,
                                           input int n, input logic a);
    logic [3:0] v;
    v = d;
    for (int i = 0; i < n; i++) begin
      case (o)
        2'b00:   v = {v[2:0], 1'b0};
        2'b01:   v = {(ArithEn && a) ? v[3] : 1'b0, v[3:1]};
        2'b10:   v = {v[2:0], v[3]};
        default: v = {v[0], v[3:1]};
      endcase
    end
    return v;
  endfunction

  // Runs one operation: drives start in idle, checks h every cycle and the
  // result and latency of the done pulse against the scoreboard.
  task automatic do_op(input string name, input logic [3:0] d, input logic [1:0] o,
                       input logic [2:0] c, input logic a, input logic [3:0] exp_q);
    exp_t   e;
    exp_t   got;
    logic [1:0] exp_h;
    bit     seen;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_start got=%b want=1", name, ready);
    end
    start = 1'b1;
    dato  = d;
    op    = o;
    cant  = c;
    arith = a;
    e.q   = exp_q;
    e.lat = int'(c) + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Disturb the inputs; the running operation must ignore them.
    dato  = 4'($urandom);
    op    = 2'($urandom);
    cant  = 3'($urandom);
    arith = 1'($urandom);
    seen  = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      @(negedge clk);
      exp_h = (n <= int'(c)) ? (o[0] ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (h !== exp_h) begin
        failures++;
        $display("FAIL %s h_cycle%0d got=%b want=%b", name, n, h, exp_h);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        got  = sb.pop_front();
        checks++;
        if (q !== got.q) begin
          failures++;
          $display("FAIL %s result got=%b want=%b", name, q, got.q);
        end
        checks++;
        if (n !== got.lat) begin
          failures++;
          $display("FAIL %s latency got=%0d want=%0d", name, n, got.lat);
        end
      end
    end
    if (!seen) begin
      failures++;
      checks++;
      $display("FAIL %s done_timeout got=none want=%0d", name, e.lat);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    dato  = 4'b0000;
    op    = 2'b00;
    cant  = 3'd0;
    arith = 1'b0;
    #12;
    checks++;
    if ({q, f, h, il, ir, ready, done} !== {4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0})
    begin
      failures++;
      $display("FAIL reset_state got q=%b f=%b h=%b il=%b ir=%b ready=%b done=%b want 0000/0000/00/0/0/1/0",
               q, f, h, il, ir, ready, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_examples();
    do_op("lsl_1011_2", 4'b1011, 2'b00, 3'd2, 1'b0, 4'b1100);
    do_op("ror_1001_3", 4'b1001, 2'b11, 3'd3, 1'b0, 4'b0011);
    do_op("rol_0110_0", 4'b0110, 2'b10, 3'd0, 1'b0, 4'b0110);
    do_op("lsr_arith",  4'b1000, 2'b01, 3'd2, 1'b1, ArithEn ? 4'b1110 : 4'b0010);
    do_op("lsr_plain",  4'b1000, 2'b01, 3'd2, 1'b0, 4'b0010);
    do_op("rol_1001_7", 4'b1001, 2'b10, 3'd7, 1'b0, 4'b1100);
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    logic [1:0] o;
    logic [2:0] c;
    logic       a;
    for (int i = 0; i < 10; i++) begin
      d = 4'($urandom);
      o = 2'($urandom);
      c = 3'($urandom);
      a = 1'($urandom);
      do_op("random", d, o, c, a, ref_shift(d, o, int'(c), a));
    end
  endtask

  task automatic test_start_in_shift();
    exp_t got;
    bit   seen;
    int   dones;
    @(posedge clk);
    #1;
    start = 1'b1;
    dato  = 4'b0001;
    op    = 2'b00;
    cant  = 3'd3;
    sb.push_back('{q: 4'b1000, lat: 4});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    // Mid-operation request with different data must be dropped.
    start = 1'b1;
    dato  = 4'b1111;
    cant  = 3'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int n = 3; n <= 12 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        got  = sb.pop_front();
        checks++;
        if (q !== got.q || n !== got.lat) begin
          failures++;
          $display("FAIL start_in_shift got q=%b lat=%0d want q=%b lat=%0d",
                   q, n, got.q, got.lat);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL start_in_shift done_timeout got=none want=4");
      void'(sb.pop_front());
    end
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL start_in_shift_queued got dones=%0d ready=%b want dones=0 ready=1",
               dones, ready);
    end
  endtask

  task automatic test_clr_start_idle();
    int dones;
    // q holds 1000 from the previous operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    clr   = 1'b1;
    dato  = 4'b1111;
    cant  = 3'd2;
    @(negedge clk);
    checks++;
    if (h !== 2'b11) begin
      failures++;
      $display("FAIL clr_start_h got=%b want=11", h);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    clr   = 1'b0;
    checks++;
    if (q !== 4'b0000 || ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_start_state got q=%b ready=%b want q=0000 ready=1", q, ready);
    end
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || ready !== 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL clr_start_idle got bad_cycles=%0d want=0", dones);
    end
  endtask

  task automatic test_clr_in_shift();
    int dones;
    @(posedge clk);
    #1;
    start = 1'b1;
    dato  = 4'b0001;
    op    = 2'b00;
    cant  = 3'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (h !== 2'b11 || q !== 4'b0100) begin
      failures++;
      $display("FAIL clr_shift_step3 got h=%b q=%b want h=11 q=0100", h, q);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (q !== 4'b0000 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL clr_shift_abort got q=%b ready=%b done=%b want 0000/1/0", q, ready, done);
    end
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL clr_shift_no_done got=%0d want=0", dones);
    end
  endtask

  task automatic test_reset_in_shift();
    int dones;
    @(posedge clk);
    #1;
    start = 1'b1;
    dato  = 4'b0011;
    op    = 2'b00;
    cant  = 3'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000 || ready !== 1'b1 || done !== 1'b0 || h !== 2'b00) begin
      failures++;
      $display("FAIL reset_async got q=%b ready=%b done=%b h=%b want 0000/1/0/00",
               q, ready, done, h);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || ready !== 1'b1 || q !== 4'b0000) begin
      failures++;
      $display("FAIL reset_no_done got dones=%0d ready=%b q=%b want 0/1/0000", dones, ready, q);
    end
    // Normal operation resumes after reset.
    do_op("after_reset", 4'b0101, 2'b11, 3'd1, 1'b0, 4'b1010);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_examples();
    test_back_to_back();
    test_start_in_shift();
    test_clr_start_idle();
    test_clr_in_shift();
    test_reset_in_shift();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/secuenciador_corrimiento.md
SECUENCIADOR_CORRIMIENTO -- requirements
Module: secuenciador_corrimiento

Interface
REQ-001 Ports SHALL be: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-002 start input 1: request a multi-step shift; sampled only in IDLE.
REQ-003 dato input 4: initial operand, captured on accepted start.
REQ-004 op input 2: 00 logical left, 01 logical right, 10 rotate left, 11 rotate right; captured on accepted start.
REQ-005 cant input 3: number of single-bit steps, 0..7; captured on accepted start.
REQ-006 arith input 1: arithmetic right shift when op=01; meaningful only with ARITH_SHIFT_EN.
REQ-007 clr input 1: synchronous clear/abort.
REQ-008 s_i input 4: result returned by the downstream 4-bit shift unit.
REQ-009 h output 2: shift-unit select. 00 pass, 01 left with s[0]=il, 10 right with s[3]=ir, 11 zero.
REQ-010 f output 4: operand to the shift unit; always equals the internal register r.
REQ-011 il output 1 and ir output 1: serial fill bits to the shift unit.
REQ-012 q output 4: current register value r.
REQ-013 ready output 1: high in IDLE; done output 1: one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE, with a registered 3-bit down-counter cnt.
REQ-015 IDLE: if start=1 and clr=0, set r<=dato, latch op/arith, set cnt<=cant, and go to SHIFT (cant!=0) or DONE (cant=0).
REQ-016 SHIFT: each cycle, set r<=s_i and cnt<=cnt-1; when cnt=1, go to DONE; exactly cant steps are performed.
REQ-017 DONE: done=1 for exactly one cycle, r is held, then go to IDLE.
REQ-018 Latency: done SHALL be high cant+1 cycles after the edge that accepts start.
REQ-019 h SHALL be 01 in SHIFT for op 00/10, 10 in SHIFT for op 01/11, 11 on a clr cycle, and 00 otherwise.
REQ-020 il SHALL be r[3] for rotate left and 0 otherwise; ir SHALL be r[0] for rotate right, r[3] for arithmetic right, and 0 otherwise.
REQ-021 start in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-022 clr=1 in any state SHALL drive h=11, set r<=s_i (zero), cnt<=0 and state<=IDLE, and suppress done; clr beats a simultaneous start.
REQ-023 Changes to dato, op, cant or arith after acceptance SHALL NOT affect the running operation.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, r=0000 and cnt=0, giving q=0000, f=0000, h=00, il=0, ir=0, ready=1 and done=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; operation resumes on the first clk edge after release.

Configuration
REQ-026 With macro ARITH_SHIFT_EN defined, op=01 with arith=1 SHALL fill ir=r[3] (sign-preserving right shift).
REQ-027 Without ARITH_SHIFT_EN, the arith port SHALL be ignored and op=01 SHALL always fill ir=0; all other behaviour is identical.

Verification
REQ-028 Reset: assert rst_n=0 mid-SHIFT -> q=0000, ready=1, done=0 asynchronously; no done pulse after release.
REQ-029 dato=1011, op=00, cant=2 -> h=01 for 2 cycles, q=1100, done 3 cycles after start.
REQ-030 dato=1001, op=11, cant=3 -> q=0011 at done; dato=0110, op=10, cant=0 -> q=0110, done 1 cycle after start, h stays 00.
REQ-031 dato=1000, op=01, arith=1, cant=2 -> q=1110 with ARITH_SHIFT_EN and q=0010 without.
REQ-032 start pulsed during SHIFT is ignored; clr together with start in IDLE -> h=11, q=0000, ready stays 1, no done.
REQ-033 clr during SHIFT (op=00, cant=7, third step) -> next cycle q=0000 and IDLE, no done pulse.
